// File: rtl/register_bank_pkg.sv
// Shared definitions for the register_bank storage register: default
// parameter values, the control-pair type used by RTL and benches, and a parity helper.
package register_bank_pkg;

  localparam int          DEFAULT_WIDTH     = 8;
  localparam logic [63:0] DEFAULT_RST_VALUE = '0;

  // rst is active-low; wr_en is active-high.
  typedef struct packed {
    logic rst;
    logic wr_en;
  } ctrl_t;

  // Zero-extension to 64 bits does not change the XOR reduction.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/register_bank_cell.sv
// One storage bit of register_bank: active-low synchronous reset dominates,
// then write enable, otherwise hold.
module register_bank_cell (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic d,
  input  logic rst_val,
  output logic q
);

  logic q_d;
  logic q_q;

  // Ternary form keeps an X on wr_en visible on q instead of silently holding.
  always_comb begin
    q_d = !rst ? rst_val : (wr_en ? d : q_q);
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/register_bank.sv
// WIDTH-bit register with write enable and synchronous active-low clear.
// Defining REGISTER_BANK_PARITY_EN adds a registered even-parity output.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VALUE = DEFAULT_RST_VALUE[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
`ifdef REGISTER_BANK_PARITY_EN
  ,
  output logic             parity
`endif
);

  ctrl_t ctrl;

  assign ctrl = '{rst: rst, wr_en: wr_en};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    register_bank_cell u_cell (
      .clk     (clk),
      .rst     (ctrl.rst),
      .wr_en   (ctrl.wr_en),
      .d       (in[i]),
      .rst_val (RST_VALUE[i]),
      .q       (out[i])
    );
  end

`ifdef REGISTER_BANK_PARITY_EN
  logic parity_d;
  logic parity_q;

  // Computed from the incoming data so the bit lands on the same edge as out.
  always_comb begin
    parity_d = !ctrl.rst ? even_parity(64'(RST_VALUE))
             : (ctrl.wr_en ? even_parity(64'(in)) : parity_q);
  end

  always_ff @(posedge clk) begin
    parity_q <= parity_d;
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: 8-, 1- and 32-bit instances checked
// against a reference model; parity checked when REGISTER_BANK_PARITY_EN is defined.
module tb_register_bank;
  import register_bank_pkg::*;

  localparam logic [7:0]  R8  = 8'h00;
  localparam logic        R1  = 1'b1;
  localparam logic [31:0] R32 = 32'h1234_5678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en;
  logic [7:0]  in8;
  logic [0:0]  in1;
  logic [31:0] in32;
  logic [7:0]  out8;
  logic [0:0]  out1;
  logic [31:0] out32;
`ifdef REGISTER_BANK_PARITY_EN
  logic par8, par1, par32;
`endif

  register_bank #(.WIDTH(8), .RST_VALUE(R8)) u_dut8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .in(in8), .out(out8)
`ifdef REGISTER_BANK_PARITY_EN
    , .parity(par8)
`endif
  );

  register_bank #(.WIDTH(1), .RST_VALUE(R1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .in(in1), .out(out1)
`ifdef REGISTER_BANK_PARITY_EN
    , .parity(par1)
`endif
  );

  register_bank #(.WIDTH(32), .RST_VALUE(R32)) u_dut32 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .in(in32), .out(out32)
`ifdef REGISTER_BANK_PARITY_EN
    , .parity(par32)
`endif
  );

  typedef struct {
    logic [7:0]  o8;
    logic        o1;
    logic [31:0] o32;
    string       name;
  } exp_t;

  exp_t sb[$];

  // Reference model: the value the register should hold after the next edge.
  logic [7:0]  m8;
  logic        m1;
  logic [31:0] m32;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [7:0] d8,
                       input logic d1, input logic [31:0] d32, input string nm);
    exp_t e;
    @(negedge clk);
    rst   = r;
    wr_en = w;
    in8   = d8;
    in1   = d1;
    in32  = d32;
    if (!r) begin
      m8 = R8; m1 = R1; m32 = R32;
    end else if (w) begin
      m8 = d8; m1 = d1; m32 = d32;
    end
    e.o8 = m8; e.o1 = m1; e.o32 = m32; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: the register presents a value every cycle, one edge after its stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, "_out8"},  64'(out8),  64'(e.o8));
        chk({e.name, "_out1"},  64'(out1),  64'(e.o1));
        chk({e.name, "_out32"}, 64'(out32), 64'(e.o32));
`ifdef REGISTER_BANK_PARITY_EN
        chk({e.name, "_par8"},  64'(par8),  64'(^e.o8));
        chk({e.name, "_par1"},  64'(par1),  64'(e.o1));
        chk({e.name, "_par32"}, 64'(par32), 64'(^e.o32));
`endif
        // Mid-cycle input changes must not reach out.
        in8  = 8'($urandom);
        in32 = $urandom;
      end
    end
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; in8 = '0; in1 = '0; in32 = '0;
    m8 = R8; m1 = R1; m32 = R32;

    drive(1'b0, 1'b0, 8'hAA, 1'b0, 32'h0000_0000, "rst_idle");
    drive(1'b0, 1'b1, 8'hFF, 1'b0, 32'hFFFF_FFFF, "rst_dominates");
    drive(1'b1, 1'b1, 8'hFA, 1'b1, 32'hDEAD_BEEF, "write_fa");
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 8'h0F, 1'b0, 32'h0000_000F, "hold");
    drive(1'b1, 1'b1, 8'h01, 1'b0, 32'h0000_0001, "b2b_1");
    drive(1'b1, 1'b1, 8'h02, 1'b1, 32'h0000_0002, "b2b_2");
    drive(1'b1, 1'b1, 8'h03, 1'b0, 32'h0000_0003, "b2b_3");
    drive(1'b1, 1'b1, 8'h5A, 1'b1, 32'hA5A5_5A5A, "pre_5a");
    drive(1'b0, 1'b1, 8'hC3, 1'b0, 32'hC3C3_C3C3, "mid_rst");
    drive(1'b1, 1'b1, 8'hC3, 1'b0, 32'hC3C3_C3C3, "reload_c3");
    drive(1'b1, 1'b1, 8'h07, 1'b1, 32'h0000_0007, "par_07");
    drive(1'b1, 1'b1, 8'h03, 1'b0, 32'h0000_0003, "par_03");
    drive(1'b0, 1'b0, 8'h07, 1'b1, 32'h0000_0007, "par_rst");

    for (int i = 0; i < 300; i++)
      drive(($urandom_range(0, 9) != 0), 1'($urandom), 8'($urandom),
            1'($urandom), $urandom, "random");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
